// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: frame geometry and the
// transmitter FSM state encodings.
package uart_pkg;

    localparam int UART_DATA_W     = 8;
    localparam int UART_FRAME_BITS = 10;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with a combinational head read; pointers wrap
// naturally and the occupancy count is kept one bit wider than the pointers.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt pointers.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign rdata = mem[rd_ptr_reg];
    assign count = count_reg;
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/uart_tx_stage.sv
// 8N1 UART transmitter: bytes arrive over valid/ready into a small FIFO and
// are shifted out LSB first, back-to-back when the FIFO stays non-empty.
module uart_tx_stage
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic       push;
    logic       pop;
    uart_byte_t fifo_rdata;
    logic       fifo_full;
    logic       fifo_empty;

    logic [1:0]  state_reg,   state_next;
    logic [15:0] baud_reg,    baud_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    uart_byte_t  shift_reg,   shift_next;
    logic        tx_reg,      tx_next;
    logic        baud_last;

    // Ready comes only from the registered count, so a full FIFO never
    // accepts even on an edge where a pop frees a slot.
    assign in_ready = !fifo_full;
    assign push     = in_valid && in_ready;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign baud_last = (baud_reg == DIV_LAST);

    always_comb begin
        state_next   = state_reg;
        baud_next    = baud_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_next = fifo_rdata;
                    tx_next    = 1'b0;
                    baud_next  = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (baud_last) begin
                    baud_next    = '0;
                    tx_next      = shift_reg[0];
                    bit_idx_next = '0;
                    state_next   = ST_DATA;
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = ST_STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    baud_next = '0;
                    // Chain straight into the next start bit to avoid an idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        shift_next = fifo_rdata;
                        tx_next    = 1'b0;
                        state_next = ST_START;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    baud_next = baud_reg + 16'd1;
                end
            end
            default: begin
                tx_next    = 1'b1;
                baud_next  = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
        end
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != ST_IDLE) || !fifo_empty;

endmodule
